// File: rtl/dct_butterfly_stage.sv
// ---------------------------------------------------------------------------
// dct_butterfly_stage
//
// First butterfly stage of an N-point DCT. Samples arrive serially, one per
// accepted cycle, in index order 0..N-1. When the last sample of a frame is
// accepted, the stage forms the N/2 even sums a_k = x_k + x_(N-1-k) and the
// N/2 odd differences b_k = x_k - x_(N-1-k). It registers them into a held
// output that is released through a valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer keeps valid and its data
// stable until that transfer happens. Ready may depend on internal state but
// never on valid of the same interface.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   abort      discard the partially collected frame (idx returns to 0)
//   in_valid   in_data carries a sample
//   in_ready   stage can accept a sample this cycle
//   in_data    signed sample x_idx, WIDTH_X bits
//   out_valid  out_even / out_odd hold a complete result
//   out_ready  downstream consumes the held result
//   out_even   a_k packed at [k*WIDTH_Y +: WIDTH_Y], k = 0..N/2-1
//   out_odd    b_k packed at [k*WIDTH_Y +: WIDTH_Y], k = 0..N/2-1
//   ovf        sticky: some registered a_k / b_k did not fit in WIDTH_Y
// ---------------------------------------------------------------------------
module dct_butterfly_stage #(
    parameter int N       = 16,
    parameter int WIDTH_X = 17,
    parameter int WIDTH_Y = 18,
    parameter bit SAT     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [WIDTH_X-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(N/2)*WIDTH_Y-1:0]     out_even,
    output logic [(N/2)*WIDTH_Y-1:0]     out_odd,
    output logic                         ovf
);

    localparam int IW   = $clog2(N);
    localparam int HALF = N / 2;
    localparam int SW   = WIDTH_X + 1;
    // Comparison width: wide enough for both the exact sum and the output
    // limits, plus a sign bit, so the range test is valid for any WIDTH_Y.
    localparam int CW   = ((WIDTH_Y > SW) ? WIDTH_Y : SW) + 1;

    localparam logic signed [CW-1:0] Y_MAX = CW'((64'sd1 <<< (WIDTH_Y - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] Y_MIN = ~Y_MAX;

    // Returns {overflow, fitted value}. When WIDTH_Y >= SW the exact value is
    // always inside the limits, so this reduces to plain sign extension.
    function automatic logic [WIDTH_Y:0] fit(input logic signed [SW-1:0] v);
        logic signed [CW-1:0] ve;
        logic                 of;
        logic [WIDTH_Y-1:0]   y;
        ve = CW'(v);
        of = (ve > Y_MAX) || (ve < Y_MIN);
        if (of && SAT) begin
            y = ve[CW-1] ? Y_MIN[WIDTH_Y-1:0] : Y_MAX[WIDTH_Y-1:0];
        end else begin
            y = ve[WIDTH_Y-1:0];
        end
        return {of, y};
    endfunction

    logic [IW-1:0]               idx;
    logic signed [WIDTH_X-1:0]   smp [N-1];
    logic                        last_slot;
    logic                        accept;
    logic                        complete;

    logic [HALF*WIDTH_Y-1:0]     even_n;
    logic [HALF*WIDTH_Y-1:0]     odd_n;
    logic                        ovf_n;
    logic signed [WIDTH_X-1:0]   lo;
    logic signed [WIDTH_X-1:0]   hi;
    logic [WIDTH_Y:0]            fs;
    logic [WIDTH_Y:0]            fd;

    assign last_slot = (idx == IW'(N - 1));
    // Only the final sample has to wait for the output register; earlier
    // samples of the next frame are collected while a result is held.
    assign in_ready  = !(last_slot && out_valid && !out_ready);
    // An aborted cycle discards whatever sample is offered with it.
    assign accept    = in_valid && in_ready && !abort;
    assign complete  = accept && last_slot;

    // Butterfly: x_(N-1) is the sample on in_data in the completing cycle,
    // so it never needs a buffer slot.
    always_comb begin
        even_n = '0;
        odd_n  = '0;
        ovf_n  = 1'b0;
        lo     = '0;
        hi     = '0;
        fs     = '0;
        fd     = '0;
        for (int k = 0; k < HALF; k++) begin
            lo = smp[k];
            hi = (k == 0) ? in_data : smp[N-1-k];
            fs = fit(SW'(lo) + SW'(hi));
            fd = fit(SW'(lo) - SW'(hi));
            even_n[k*WIDTH_Y +: WIDTH_Y] = fs[WIDTH_Y-1:0];
            odd_n[k*WIDTH_Y +: WIDTH_Y]  = fd[WIDTH_Y-1:0];
            ovf_n = ovf_n | fs[WIDTH_Y] | fd[WIDTH_Y];
        end
    end

    // Sample buffer carries no reset: its contents are rewritten before use.
    always_ff @(posedge clk) begin
        if (accept && !last_slot) begin
            smp[idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_even  <= '0;
            out_odd   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (abort) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + IW'(1);   // N is a power of two: wraps N-1 -> 0
            end

            if (complete) begin
                out_even  <= even_n;
                out_odd   <= odd_n;
                out_valid <= 1'b1;
                if (ovf_n) begin
                    ovf <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// ---------------------------------------------------------------------------
// tb_dct_butterfly_stage
//
// Three instances share one stimulus stream: a default-width stage (exact
// results), a narrow saturating stage and a narrow wrapping stage. Each task
// drives one scenario and compares outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_dct_butterfly_stage;

    logic clk;
    logic rst;
    logic abort;
    logic in_valid;
    logic [16:0] in_data;
    logic out_ready;

    logic in_ready_d, out_valid_d, ovf_d;
    logic [143:0] out_even_d, out_odd_d;
    logic in_ready_s, out_valid_s, ovf_s;
    logic [135:0] out_even_s, out_odd_s;
    logic in_ready_w, out_valid_w, ovf_w;
    logic [135:0] out_even_w, out_odd_w;

    int n_cmp;
    int n_fail;

    dct_butterfly_stage #(.N(16), .WIDTH_X(17), .WIDTH_Y(18), .SAT(1'b1)) dut_d (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_data(in_data), .out_valid(out_valid_d), .out_ready(out_ready),
        .out_even(out_even_d), .out_odd(out_odd_d), .ovf(ovf_d)
    );

    dct_butterfly_stage #(.N(16), .WIDTH_X(17), .WIDTH_Y(17), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_even(out_even_s), .out_odd(out_odd_s), .ovf(ovf_s)
    );

    dct_butterfly_stage #(.N(16), .WIDTH_X(17), .WIDTH_Y(17), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_even(out_even_w), .out_odd(out_odd_w), .ovf(ovf_w)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] lane18(input logic [143:0] bus, input int k);
        return bus[k*18 +: 18];
    endfunction

    function automatic logic [16:0] lane17(input logic [135:0] bus, input int k);
        return bus[k*17 +: 17];
    endfunction

    // ---------------- driver ----------------
    // Offers one sample and waits (bounded) until it is accepted.
    task automatic send_sample(input int v);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = v[16:0];
        #1;
        for (int c = 0; c < 100 && !done; c++) begin
            done = in_ready_d;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted, in_ready=%0b required 1", v, in_ready_d);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_d); end
        n_cmp++; if (out_even_d !== '0 || out_odd_d !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h want 0", out_even_d, out_odd_d); end
        n_cmp++; if (ovf_d !== 1'b0 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b%0b%0b want 000", ovf_d, ovf_s, ovf_w); end
        n_cmp++; if (in_ready_d !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready_d); end
    endtask

    task automatic test_ramp();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_sample(i);
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL ramp_early_valid: got %0b want 0", out_valid_d); end
        send_sample(15);
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL ramp_valid: got %0b want 1", out_valid_d); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (lane18(out_even_d, k) !== 18'(15)) begin n_fail++; $display("FAIL ramp_even[%0d]: got %0d want 15", k, $signed(lane18(out_even_d, k))); end
            n_cmp++; if (lane18(out_odd_d, k) !== 18'(2*k-15)) begin n_fail++; $display("FAIL ramp_odd[%0d]: got %0d want %0d", k, $signed(lane18(out_odd_d, k)), 2*k-15); end
            n_cmp++; if (lane17(out_odd_s, k) !== 17'(2*k-15)) begin n_fail++; $display("FAIL ramp_odd_narrow[%0d]: got %0d want %0d", k, $signed(lane17(out_odd_s, k)), 2*k-15); end
        end
        n_cmp++; if (ovf_d !== 1'b0 || ovf_s !== 1'b0) begin n_fail++; $display("FAIL ramp_ovf: got %0b%0b want 00", ovf_d, ovf_s); end
        tick();
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL ramp_valid_one_cycle: got %0b want 0", out_valid_d); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_sample(10*i);
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %0b want 1", out_valid_d); end
        for (int i = 0; i < 15; i++) send_sample(1000-i);
        in_valid = 1'b1;
        in_data  = 17'(985);
        #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (in_ready_d !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %0b want 0", c, in_ready_d); end
            n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", c, out_valid_d); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++; if (lane18(out_even_d, k) !== 18'(150) || lane18(out_odd_d, k) !== 18'(20*k-150)) begin
                    n_fail++; $display("FAIL bp_hold_data[%0d][%0d]: got %0d/%0d want 150/%0d", c, k,
                        $signed(lane18(out_even_d, k)), $signed(lane18(out_odd_d, k)), 20*k-150);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready_d !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", in_ready_d); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %0b want 1", out_valid_d); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (lane18(out_even_d, k) !== 18'(1985) || lane18(out_odd_d, k) !== 18'(15-2*k)) begin
                n_fail++; $display("FAIL bp_second_data[%0d]: got %0d/%0d want 1985/%0d", k,
                    $signed(lane18(out_even_d, k)), $signed(lane18(out_odd_d, k)), 15-2*k);
            end
        end
        tick();
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL bp_second_clear: got %0b want 0", out_valid_d); end
    endtask

    task automatic test_overflow();
        int x;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = 0;
            if (i == 0 || i == 15) x = 65535;
            if (i == 1) x = -65536;
            if (i == 14) x = -1;
            if (i == 15) begin
                n_cmp++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin n_fail++; $display("FAIL ovf_before_register: got %0b%0b want 00", ovf_s, ovf_w); end
            end
            send_sample(x);
        end
        n_cmp++; if (out_valid_s !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %0b want 1", out_valid_s); end
        // saturating narrow stage
        n_cmp++; if (lane17(out_even_s, 0) !== 17'(65535)) begin n_fail++; $display("FAIL sat_a0: got %0d want 65535", $signed(lane17(out_even_s, 0))); end
        n_cmp++; if (lane17(out_even_s, 1) !== 17'(-65536)) begin n_fail++; $display("FAIL sat_a1: got %0d want -65536", $signed(lane17(out_even_s, 1))); end
        n_cmp++; if (lane17(out_odd_s, 0) !== 17'(0)) begin n_fail++; $display("FAIL sat_b0: got %0d want 0", $signed(lane17(out_odd_s, 0))); end
        n_cmp++; if (lane17(out_odd_s, 1) !== 17'(-65535)) begin n_fail++; $display("FAIL sat_b1: got %0d want -65535", $signed(lane17(out_odd_s, 1))); end
        n_cmp++; if (lane17(out_even_s, 7) !== 17'(0)) begin n_fail++; $display("FAIL sat_a7: got %0d want 0", $signed(lane17(out_even_s, 7))); end
        // wrapping narrow stage
        n_cmp++; if (lane17(out_even_w, 0) !== 17'(-2)) begin n_fail++; $display("FAIL wrap_a0: got %0d want -2", $signed(lane17(out_even_w, 0))); end
        n_cmp++; if (lane17(out_even_w, 1) !== 17'(65535)) begin n_fail++; $display("FAIL wrap_a1: got %0d want 65535", $signed(lane17(out_even_w, 1))); end
        n_cmp++; if (lane17(out_odd_w, 1) !== 17'(-65535)) begin n_fail++; $display("FAIL wrap_b1: got %0d want -65535", $signed(lane17(out_odd_w, 1))); end
        // exact default-width stage
        n_cmp++; if (lane18(out_even_d, 0) !== 18'(131070)) begin n_fail++; $display("FAIL exact_a0: got %0d want 131070", $signed(lane18(out_even_d, 0))); end
        n_cmp++; if (lane18(out_even_d, 1) !== 18'(-65537)) begin n_fail++; $display("FAIL exact_a1: got %0d want -65537", $signed(lane18(out_even_d, 1))); end
        n_cmp++; if (ovf_s !== 1'b1 || ovf_w !== 1'b1 || ovf_d !== 1'b0) begin n_fail++; $display("FAIL ovf_set: got d%0b s%0b w%0b want d0 s1 w1", ovf_d, ovf_s, ovf_w); end
        // clean frame: flag stays sticky
        for (int i = 0; i < 16; i++) send_sample(1);
        n_cmp++; if (lane17(out_even_s, 3) !== 17'(2) || lane17(out_odd_w, 3) !== 17'(0)) begin n_fail++; $display("FAIL clean_data: got %0d/%0d want 2/0", $signed(lane17(out_even_s, 3)), $signed(lane17(out_odd_w, 3))); end
        n_cmp++; if (ovf_s !== 1'b1 || ovf_w !== 1'b1 || ovf_d !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: got d%0b s%0b w%0b want d0 s1 w1", ovf_d, ovf_s, ovf_w); end
        tick();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_sample(7);
        in_valid = 1'b1; in_data = 17'(55); abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL abort_mid_valid: got %0b want 0", out_valid_d); end
        // abort coinciding with the last sample produces nothing
        for (int i = 0; i < 15; i++) send_sample(3);
        in_valid = 1'b1; in_data = 17'(3); abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL abort_last_valid: got %0b want 0", out_valid_d); end
        for (int i = 0; i < 16; i++) begin
            send_sample(100);
            if (i < 15) begin
                n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL abort_spurious[%0d]: got %0b want 0", i, out_valid_d); end
            end
        end
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL abort_fresh_valid: got %0b want 1", out_valid_d); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (lane18(out_even_d, k) !== 18'(200) || lane18(out_odd_d, k) !== 18'(0)) begin
                n_fail++; $display("FAIL abort_fresh_data[%0d]: got %0d/%0d want 200/0", k,
                    $signed(lane18(out_even_d, k)), $signed(lane18(out_odd_d, k)));
            end
        end
        tick();
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL abort_single_result: got %0b want 0", out_valid_d); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_sample(i+1);
        for (int i = 0; i < 12; i++) send_sample(9);
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL rstmid_held: got %0b want 1", out_valid_d); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid_d !== 1'b0 || out_valid_s !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b%0b want 00", out_valid_d, out_valid_s); end
        n_cmp++; if (out_even_d !== '0 || out_odd_d !== '0 || out_even_s !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h/%h want 0", out_even_d, out_odd_d); end
        n_cmp++; if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %0b%0b want 00", ovf_s, ovf_w); end
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_sample(5*i-40);
        n_cmp++; if (out_valid_d !== 1'b0) begin n_fail++; $display("FAIL rstmid_early: got %0b want 0", out_valid_d); end
        send_sample(35);
        n_cmp++; if (out_valid_d !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_after: got %0b want 1", out_valid_d); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (lane18(out_even_d, k) !== 18'(-5) || lane18(out_odd_d, k) !== 18'(10*k-75)) begin
                n_fail++; $display("FAIL rstmid_data[%0d]: got %0d/%0d want -5/%0d", k,
                    $signed(lane18(out_even_d, k)), $signed(lane18(out_odd_d, k)), 10*k-75);
            end
        end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_butterfly_stage.md
Name: dct_butterfly_stage

Overview:
- Parametrised first butterfly stage for an N-point DCT.
- Collects one sample per cycle into an N-entry frame buffer.
- When the frame is complete, produces the N/2 even sums a_k = x_k + x_(N-1-k) and N/2 odd differences b_k = x_k - x_(N-1-k).
- Outputs are held under a valid/ready handshake and feed the N/2-point even-part DCT and the odd-part shift-add network.
- Adds serial ingest, backpressure, frame abort and optional saturation.

Parameters:
- N, 16, frame length; power of two, 4..64.
- WIDTH_X, 17, signed input sample width.
- WIDTH_Y, 18, signed output width.
- SAT, 1, overflow handling when WIDTH_Y < WIDTH_X+1: 1 = saturate, 0 = wrap (keep low bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- abort  in  1  discard the partially collected frame.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  stage can accept a sample this cycle.
- in_data  in  WIDTH_X  signed sample x_idx; samples arrive in order idx = 0..N-1.
- out_valid  out  1  out_even and out_odd hold a complete result.
- out_ready  in  1  downstream accepts the result.
- out_even  out  (N/2)*WIDTH_Y  a_k at bits [k*WIDTH_Y +: WIDTH_Y].
- out_odd  out  (N/2)*WIDTH_Y  b_k at bits [k*WIDTH_Y +: WIDTH_Y].
- ovf  out  1  sticky: some a_k or b_k has overflowed WIDTH_Y since reset.

Behaviour:
- Reset (rst=1 at posedge):
  - idx=0, out_valid=0, out_even=0, out_odd=0, ovf=0, buffer contents don't-care.
  - Reset has priority over all other inputs, including mid-frame and mid-handshake; the partial frame is lost.
- Accept: a sample is accepted when in_valid && in_ready.
  - The sample is written to buf[idx].
  - idx increments, wrapping from N-1 to 0.
- in_ready = !(idx==N-1 && out_valid && !out_ready).
  - Samples 0..N-2 of the next frame may be collected while a result is held.
  - The final sample stalls until the output register is free or being consumed in the same cycle.
- Compute: on the cycle that accepts sample N-1:
  - Compute all a_k and b_k combinationally from buf[0..N-2] and the incoming in_data as buf[N-1].
  - Register them into out_even and out_odd.
  - out_valid=1 from the next cycle. Latency is 1 cycle from the last-sample accept to out_valid.
- Hold: while out_valid && !out_ready, out_even and out_odd are stable.
- Output handshake:
  - out_valid && out_ready && no new completion this cycle: out_valid clears next cycle.
  - Consume and completion in the same cycle: out_valid stays 1 and the new result is loaded.
- Arithmetic:
  - Sums and differences are computed at WIDTH_X+1 bits, sign-extended, so they are exact.
  - If WIDTH_Y >= WIDTH_X+1: sign-extend to WIDTH_Y; ovf never sets.
  - Otherwise, for values outside [-2^(WIDTH_Y-1), 2^(WIDTH_Y-1)-1]:
    - SAT=1: clamp to the nearest limit.
    - SAT=0: truncate to the low WIDTH_Y bits.
    - In both cases ovf is set, but only when the result is registered.
- Abort:
  - idx returns to 0 next cycle.
  - A sample accepted in the same cycle is discarded and does not advance idx.
  - A held output is unaffected.
  - Abort in the same cycle as a last-sample accept: abort wins; no result is produced.
- in_valid=0 gaps between samples are allowed at any point; the frame resumes at the current idx.
- ovf clears only on rst.

Test Plan:
- N=16 defaults, in_data=k for k=0..15 back to back, out_ready=1 -> out_valid=1 for exactly one cycle, the cycle after sample 15; all a_k=15; b_0=-15, b_3=-9, b_7=-1; ovf=0.
- Two back-to-back frames with out_ready=0 held for 5 cycles after the first result -> in_ready=0 with idx=15 until out_ready=1; the first result is stable throughout; the second result appears on the cycle after its sample 15 is accepted; no sample is lost.
- WIDTH_Y=17, SAT=1, x_0=x_15=65535, x_1=-65536, x_14=-1, others 0 -> a_0=65535 (clamped); a_1=-65536 (clamped); b_0=0; b_1=-65535; ovf=1 and stays 1 across the next clean frame.
- Same stimulus with SAT=0 -> a_0=-2 (wrapped, from 131070); a_1=65535 (wrapped, from -65537); ovf=1.
- abort asserted after 9 samples, then a fresh 16-sample frame of constant 100 -> exactly one result: a_k=200, b_k=0; no output for the aborted frame.
- rst asserted after 12 samples with out_valid=1 held -> next cycle out_valid=0, outputs=0, idx=0; a following full frame produces a correct result 1 cycle after its last sample.
